alu_exec_unit: RTL

- Execute stage directly downstream of the operand mux/register pair; consumes the latched A and B operands and produces the execute result for writeback or bus.
- Single-cycle integer ops complete in one cycle. Multiply and divide run on a shared iterative radix-2 datapath over 32 cycles.
- Handshake is start/busy/done.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 108 ++++++++++
 rtl/alu_exec_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: widths, aluOp encodings and the
// mul/div sequencer state type.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide, one step per cycle.
// done is a combinational completion strobe; the caller registers the result.
module alu_muldiv_iter #(
  parameter int unsigned XLEN = alu_pkg::XLEN,
  parameter int unsigned ITER = alu_pkg::ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import alu_pkg::*;

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [3:0]      op_q;
  logic            rem_q, neg_q, neg_r;

  logic            mul_in, sgn_in, rem_in, div_zero, div_ovf, special, launch, last, mul_q;
  logic [XLEN-1:0] special_res, a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_sub, div_hi_n, div_lo_n, quo, rmd, fin_res;
  logic            div_ge;

  assign mul_in   = (op == OP_MUL) || (op == OP_MULHU);
  assign sgn_in   = (op == OP_DIV) || (op == OP_REM);
  assign rem_in   = (op == OP_REM) || (op == OP_REMU);
  assign div_zero = (b == '0);
  assign div_ovf  = sgn_in && (a == MIN_NEG) && (b == '1);
  assign special  = start && !mul_in && (div_zero || div_ovf);
  assign launch   = start && !special && (state == IDLE);
  assign special_res = div_zero ? (rem_in ? a : '1) : (rem_in ? '0 : MIN_NEG);
  assign a_mag    = (sgn_in && a[XLEN-1]) ? ('0 - a) : a;
  assign b_mag    = (sgn_in && b[XLEN-1]) ? ('0 - b) : b;

  assign mul_q = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign last  = (state == RUN) && (cnt == CW'(ITER - 1));

  // hi/lo/opnd are shared: product pair + multiplicand, or remainder/quotient + divisor
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};
    div_sh   = {hi, lo[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_sub  = div_sh[XLEN-1:0] - opnd;
    div_hi_n = div_ge ? div_sub : div_sh[XLEN-1:0];
    div_lo_n = {lo[XLEN-2:0], div_ge};
    quo      = neg_q ? ('0 - div_lo_n) : div_lo_n;
    rmd      = neg_r ? ('0 - div_hi_n) : div_hi_n;
    if (mul_q) fin_res = (op_q == OP_MUL) ? mul_lo_n : mul_hi_n;
    else       fin_res = rem_q ? rmd : quo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !special) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      op_q  <= '0;
      rem_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (launch) begin
      cnt   <= '0;
      op_q  <= op;
      rem_q <= rem_in;
      neg_q <= sgn_in && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r <= sgn_in && a[XLEN-1];
      hi    <= '0;
      lo    <= mul_in ? b : a_mag;
      opnd  <= mul_in ? a : b_mag;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      hi  <= mul_q ? mul_hi_n : div_hi_n;
      lo  <= mul_q ? mul_lo_n : div_lo_n;
    end
  end

  assign busy   = (state == RUN);
  assign done   = special || last;
  assign result = special ? special_res : fin_res;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: combinational single-cycle ALU plus optional iterative
// mul/div unit (enabled by `define ALU_MULDIV_EN). start/busy/done handshake.
module alu_exec_unit #(
  parameter int unsigned XLEN = alu_pkg::XLEN,
  parameter int unsigned ITER = alu_pkg::ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] inA,
  input  logic [XLEN-1:0] inB,
  input  logic [3:0]      aluOp,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  import alu_pkg::*;

  logic            accept, is_md;
  logic [XLEN-1:0] alu_y;

  assign accept = start && !busy;
  assign is_md  = (aluOp >= OP_MUL);

  always_comb begin
    alu_y = '0;
    case (aluOp)
      OP_ADD:  alu_y = inA + inB;
      OP_SUB:  alu_y = inA - inB;
      OP_AND:  alu_y = inA & inB;
      OP_OR:   alu_y = inA | inB;
      OP_XOR:  alu_y = inA ^ inB;
      OP_SLL:  alu_y = inA << inB[4:0];
      OP_SRL:  alu_y = inA >> inB[4:0];
      OP_SRA:  alu_y = XLEN'($signed(inA) >>> inB[4:0]);
      OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(inA) < $signed(inB))};
      OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (inA < inB)};
      default: alu_y = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;

  alu_muldiv_iter #(.XLEN(XLEN), .ITER(ITER)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_md),
    .op     (aluOp),
    .a      (inA),
    .b      (inB),
    .busy   (busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !is_md) begin
        result  <= alu_y;
        illegal <= 1'b0;
        done    <= 1'b1;
      end else if (md_done) begin
        result  <= md_result;
        illegal <= 1'b0;
        done    <= 1'b1;
      end
    end
  end
`else
  assign busy = 1'b0;

  // ITER only sizes the iterative datapath, which this build omits
  if (ITER != XLEN) begin : g_iter_ne_xlen
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        result  <= is_md ? '0 : alu_y;
        illegal <= is_md;
        done    <= 1'b1;
      end
    end
  end
`endif

endmodule
